compare_seq_ctrl: RTL
=====================

// Module: compare_seq_ctrl
// PURPOSE
//  Sequencer for MSB-first, bit-serial magnitude comparison of two WIDTH-bit operands.
//  Captures operands on a start pulse and examines one bit pair per clock, running gt/lt/eq flags.
//  Terminates early on the first differing bit when EARLY_EXIT=1.
//  Serial, area-lean alternative to the flat 8-bit comparator; start/busy/done handshake for a host FSM.
// PARAMETERS
//  WIDTH      8  operand width in bits (>=2)
//  EARLY_EXIT 1  1: finish at first differing bit; 0: always scan all WIDTH bits
//  CW = $clog2(WIDTH+1), derived localparam, not overridable
// PORTS
//  clk     in   1      rising-edge clock, only clock
//  rst_n   in   1      synchronous active-low reset
//  start   in   1      request; accepted only in IDLE
//  a       in   WIDTH  operand A, sampled on accepted start
//  b       in   WIDTH  operand B, sampled on accepted start
//  busy    out  1      high in RUN and DONE
//  done    out  1      one-cycle pulse, result valid
//  gt      out  1      A > B
//  lt      out  1      A < B
//  eq      out  1      A == B
//  cycles  out  CW     number of bit pairs examined for the last result
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; busy, done, gt, lt, eq = 0; cycles = 0; shift regs = 0.
//  - FSM states IDLE, RUN, DONE (2-bit encoding, unused code -> IDLE).
//  - IDLE: start=1 -> copy a,b to shift regs; idx=WIDTH-1; run flags gt_r=lt_r=0, eq_r=1; cnt=0; -> RUN.
//    Published gt/lt/eq/cycles are not altered on entry to RUN.
//  - RUN, every cycle: compare bit idx (MSB of shift regs); cnt+=1; shift both regs left by 1.
//    a_i=1,b_i=0 -> gt_r=1, eq_r=0;  a_i=0,b_i=1 -> lt_r=1, eq_r=0.
//    Flags are sticky: once eq_r=0, later bits change nothing.
//    Exit to DONE when idx==0, or when EARLY_EXIT=1 and the current bit differs; else idx-=1.
//  - DONE (exactly 1 cycle): done=1; gt/lt/eq/cycles load from gt_r/lt_r/eq_r/cnt -> IDLE.
//    Outputs are held until the next result's DONE cycle.
//  - Exactly one of gt/lt/eq is 1 after the first completed result.
//  - Latency: start accepted at edge T0. First differing bit at index k -> done high in cycle T0+(WIDTH-k)+1,
//    cycles=WIDTH-k. Equal operands or EARLY_EXIT=0 -> done at T0+WIDTH+1, cycles=WIDTH.
//  - start while busy=1 (including the DONE cycle) is ignored; no queueing.
//    a/b changes after capture do not affect the operation in flight.
//  - Back-to-back: start held high from DONE -> accepted in the next IDLE cycle. Minimum throughput: 1 op per (cycles+2) clocks.
//  - Reset mid-RUN/DONE: abort with no done pulse; all outputs cleared per reset rule.
//  - No combinational path from inputs to outputs; all outputs registered.
// TESTING
//  1. W=8,EE=1: a=8'h80,b=8'h7F, start 1 cycle -> done 2 cycles after start; gt=1,lt=0,eq=0; cycles=1.
//  2. W=8,EE=1: a=b=8'h5A -> done at start+9; eq=1; cycles=8; busy high for 8 RUN + 1 DONE cycles.
//  3. W=8,EE=1: a=8'h12,b=8'h13 -> lt=1 at start+9, cycles=8.
//     Then a=8'h00,b=8'hFF -> lt=1, cycles=1.
//  4. W=8,EE=0: a=8'h80,b=8'h7F -> done at start+9, gt=1, cycles=8.
//     Checks: sticky flags; lower bits 0/1 must not flip the result.
//  5. start pulsed again during RUN and in the DONE cycle, with a/b changed mid-run
//     -> ignored; result matches the captured operands; exactly one done pulse.
//  6. rst_n=0 in 3rd RUN cycle -> next cycle busy=0, done=0, gt/lt/eq=0, cycles=0.
//     Then a fresh start a=8'h01,b=8'h00 -> gt=1, cycles=8.
//  Bench: 10k random a/b per EE setting vs behavioural >,<,== and expected cycles.

Source files
------------

// File: rtl/compare_seq_ctrl.sv
// compare_seq_ctrl: MSB-first bit-serial magnitude comparator sequencer.
// Captures a/b on an accepted start, examines one bit pair per clock and
// publishes gt/lt/eq plus the number of bit pairs examined on a one-cycle
// done pulse. With EARLY_EXIT=1 the scan stops at the first differing bit.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   request, accepted only while idle
//   a, b    WIDTH-bit operands, sampled on an accepted start
//   busy    high while running and during the done cycle
//   done    one-cycle pulse, result valid
//   gt/lt/eq  comparison result, held until the next done
//   cycles  bit pairs examined for the last result
module compare_seq_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1,
    localparam int unsigned CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CW-1:0]    cycles
);

    localparam int unsigned IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_diff;
    logic             w_gt_nxt;
    logic             w_lt_nxt;
    logic             w_eq_nxt;
    logic             w_last;
    logic [CW-1:0]    w_cnt_nxt;

    // Current bit pair sits at the MSB of the shift registers.
    assign w_a_bit   = r_a[WIDTH-1];
    assign w_b_bit   = r_b[WIDTH-1];
    assign w_diff    = w_a_bit ^ w_b_bit;

    // Flags only move while still equal, which makes them sticky.
    assign w_gt_nxt  = r_gt | (r_eq & w_a_bit & ~w_b_bit);
    assign w_lt_nxt  = r_lt | (r_eq & ~w_a_bit & w_b_bit);
    assign w_eq_nxt  = r_eq & ~w_diff;

    assign w_last    = (r_idx == '0) || (EARLY_EXIT && w_diff);
    assign w_cnt_nxt = r_cnt + CW'(1);

    // Sequencer with registered outputs; done/result load on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
            cycles  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= IW'(WIDTH - 1);
                        r_cnt   <= '0;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_eq    <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_a   <= {r_a[WIDTH-2:0], 1'b0};
                    r_b   <= {r_b[WIDTH-2:0], 1'b0};
                    r_cnt <= w_cnt_nxt;
                    r_gt  <= w_gt_nxt;
                    r_lt  <= w_lt_nxt;
                    r_eq  <= w_eq_nxt;
                    if (w_last) begin
                        done    <= 1'b1;
                        gt      <= w_gt_nxt;
                        lt      <= w_lt_nxt;
                        eq      <= w_eq_nxt;
                        cycles  <= w_cnt_nxt;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
